// File: rtl/video_core_arbiter.sv
// Video core arbiter: forwards one of NUM_SRC pixel streams to a single
// registered sink and switches sources only on the target's start-of-frame.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_sel                requested source (>= NUM_SRC means no request)
//   sink_stall             downstream stall, fanned out to src_stall
//   src_vld/sof/frame      per-source stream inputs
//   src_stall              per-source stall (all equal to sink_stall)
//   sink_vld, sink_frame   registered output stream (1-cycle latency)
//   active_sel             source currently forwarded
//   switch_done            one-cycle pulse after active_sel changes
//   timeout_err            forced-switch pulse (VIDEO_ARB_TIMEOUT_EN only)
//
// Build option: define VIDEO_ARB_TIMEOUT_EN to bound the start-of-frame
// wait to TIMEOUT unstalled cycles and add the timeout_err output.

package video_pkg;
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vga_frame_t;
endpackage

module video_core_arbiter
  import video_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(NUM_SRC)-1:0] cfg_sel,
  input  logic                       sink_stall,
  input  logic [NUM_SRC-1:0]         src_vld,
  input  logic [NUM_SRC-1:0]         src_sof,
  input  vga_frame_t                 src_frame [NUM_SRC],
  output logic [NUM_SRC-1:0]         src_stall,
  output logic                       sink_vld,
  output vga_frame_t                 sink_frame,
  output logic [$clog2(NUM_SRC)-1:0] active_sel,
`ifdef VIDEO_ARB_TIMEOUT_EN
  output logic                       timeout_err,
`endif
  output logic                       switch_done
);

  localparam int SW = $clog2(NUM_SRC);

  typedef enum logic {
    RUN,
    WAIT_SOF
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] target, target_nx;
  logic [SW-1:0] active_nx;
  logic [SW-1:0] fwd;
  logic          take_tgt;
  logic          sw_nx;
  logic          cfg_ok;

`ifdef VIDEO_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt, cnt_nx;
  logic          to_nx;
`endif

  assign cfg_ok = 32'(cfg_sel) < NUM_SRC;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      target      <= '0;
      active_sel  <= '0;
      sink_vld    <= 1'b0;
      switch_done <= 1'b0;
`ifdef VIDEO_ARB_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      target      <= target_nx;
      active_sel  <= active_nx;
      // Pulses update even while stalled so they last one cycle.
      switch_done <= sw_nx;
`ifdef VIDEO_ARB_TIMEOUT_EN
      cnt         <= cnt_nx;
      timeout_err <= to_nx;
`endif
      if (!sink_stall) begin
        sink_vld <= src_vld[fwd];
      end
    end
  end

  // Payload carries no reset.
  always_ff @(posedge clk) begin
    if (!sink_stall) begin
      sink_frame <= src_frame[fwd];
    end
  end

  // Next-state logic; nothing advances while stalled.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    active_nx = active_sel;
    take_tgt  = 1'b0;
    sw_nx     = 1'b0;
`ifdef VIDEO_ARB_TIMEOUT_EN
    cnt_nx    = cnt;
    to_nx     = 1'b0;
`endif
    if (!sink_stall) begin
      unique case (state)
        RUN: begin
          if (cfg_ok && cfg_sel != active_sel) begin
            target_nx = cfg_sel;
            state_nx  = WAIT_SOF;
`ifdef VIDEO_ARB_TIMEOUT_EN
            cnt_nx    = '0;
`endif
          end
        end
        WAIT_SOF: begin
          if (cfg_ok && cfg_sel == active_sel) begin
            state_nx = RUN;
`ifdef VIDEO_ARB_TIMEOUT_EN
            cnt_nx   = '0;
`endif
          end else if (cfg_ok && cfg_sel != target) begin
            target_nx = cfg_sel;
`ifdef VIDEO_ARB_TIMEOUT_EN
            cnt_nx    = '0;
`endif
          end else if (src_vld[target] && src_sof[target]) begin
            take_tgt  = 1'b1;
            active_nx = target;
            sw_nx     = 1'b1;
            state_nx  = RUN;
`ifdef VIDEO_ARB_TIMEOUT_EN
            cnt_nx    = '0;
`endif
          end
`ifdef VIDEO_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            take_tgt  = 1'b1;
            active_nx = target;
            sw_nx     = 1'b1;
            to_nx     = 1'b1;
            state_nx  = RUN;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
`endif
        end
        default: state_nx = RUN;
      endcase
    end
  end

  // Output selection: the switch cycle already carries the target's pixel.
  always_comb begin
    fwd       = take_tgt ? target : active_sel;
    src_stall = {NUM_SRC{sink_stall}};
  end

endmodule
